// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, memory read strobe, IR handshake
// Optional sticky PC overflow stop: define IFU_PC_OVF_EN.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] iAddr,
  output logic              FETCH,
  input  logic [7:0]        instr,
  output logic [7:0]        ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              pc_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              at_top;
  logic              ovf_q;
  logic              launch;

`ifdef IFU_PC_OVF_EN
  localparam logic [ADDR_W-1:0] PC_MAX = '1;

  assign at_top = (pc == PC_MAX);

  // Set by the fetch of the last address; only reset or a jump releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (jump_en) begin
      ovf_q <= 1'b0;
    end else if (state == S_REQ && at_top) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign at_top = 1'b0;
  assign ovf_q  = 1'b0;
`endif

  assign launch = en && !ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= 8'h00;
    end else if (jump_en) begin
      // Any fetch in flight or held byte is dropped by leaving S_CAP/S_HOLD.
      pc    <= jump_addr;
      state <= en ? S_REQ : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) state <= S_REQ;
        end
        S_REQ: begin
          if (!at_top) pc <= pc + 1'b1;
          state <= S_CAP;
        end
        S_CAP: begin
          ir    <= instr;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (ir_ready) state <= launch ? S_REQ : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign iAddr    = pc;
  assign FETCH    = (state == S_REQ);
  assign ir_valid = (state == S_HOLD);
  assign pc_ovf   = ovf_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a transaction-level model
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] iAddr;
  logic       FETCH;
  logic [7:0] instr = 8'h00;
  logic [7:0] ir;
  logic       ir_valid;
  logic       ir_ready = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic       pc_ovf;

  logic [7:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iAddr(iAddr), .FETCH(FETCH),
    .instr(instr), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .pc_ovf(pc_ovf)
  );

  always #5 clk = ~clk;

  // Registered instruction memory: data appears the cycle after FETCH.
  always @(posedge clk) if (FETCH) instr <= mem[iAddr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Leaves the bench at mid-cycle 0 with reset released.
  task automatic start_run(input logic en_v, input logic rdy_v);
    rst_n = 1'b0; en = en_v; ir_ready = rdy_v; jump_en = 1'b0; jump_addr = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; ir_ready = 1'b1;
    @(negedge clk);
    checks++; if (FETCH !== 1'b0) begin errors++; $display("FAIL reset_fetch got %b want 0", FETCH); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ir_valid); end
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL reset_ir got %h want 00", ir); end
    checks++; if (iAddr !== 8'h00) begin errors++; $display("FAIL reset_iaddr got %h want 00", iAddr); end
    checks++; if (pc_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", pc_ovf); end
  endtask

  task automatic test_sequential;
    logic [7:0] exp_a;
    start_run(1'b1, 1'b1);
    checks++; if (FETCH !== 1'b0) begin errors++; $display("FAIL seq_cycle0_fetch got %b want 0", FETCH); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_a = 8'((k - 1) / 3);
      checks++;
      if (FETCH !== (k % 3 == 1)) begin errors++; $display("FAIL seq_fetch cycle %0d got %b want %b", k, FETCH, (k % 3 == 1)); end
      if (k % 3 == 1) begin
        checks++;
        if (iAddr !== exp_a) begin errors++; $display("FAIL seq_iaddr cycle %0d got %h want %h", k, iAddr, exp_a); end
      end
      checks++;
      if (ir_valid !== (k % 3 == 0)) begin errors++; $display("FAIL seq_valid cycle %0d got %b want %b", k, ir_valid, (k % 3 == 0)); end
      if (k % 3 == 0) begin
        checks++;
        if (ir !== mem[k / 3 - 1]) begin errors++; $display("FAIL seq_ir cycle %0d got %h want %h", k, ir, mem[k / 3 - 1]); end
      end
    end
  endtask

  task automatic test_stall;
    start_run(1'b1, 1'b0);
    @(negedge clk); @(negedge clk);
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || ir !== 8'hA1 || FETCH !== 1'b0) begin
        errors++; $display("FAIL stall_hold cycle %0d got valid=%b ir=%h fetch=%b want 1 a1 0", k, ir_valid, ir, FETCH);
      end
    end
    ir_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (FETCH !== 1'b1 || iAddr !== 8'h01 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL stall_resume got fetch=%b iaddr=%h valid=%b want 1 01 0", FETCH, iAddr, ir_valid);
    end
  endtask

  task automatic test_jump_cap;
    start_run(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    jump_en = 1'b1; jump_addr = 8'h40;
    @(negedge clk);
    jump_en = 1'b0;
    checks++;
    if (FETCH !== 1'b1 || iAddr !== 8'h40 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL jump_cap_req got fetch=%b iaddr=%h valid=%b want 1 40 0", FETCH, iAddr, ir_valid);
    end
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL jump_cap_gap got valid=%b want 0", ir_valid); end
    @(negedge clk);
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[8'h40]) begin
      errors++; $display("FAIL jump_cap_data got valid=%b ir=%h want 1 %h", ir_valid, ir, mem[8'h40]);
    end
  endtask

  task automatic test_jump_vs_ready;
    start_run(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    jump_en = 1'b1; jump_addr = 8'h20;
    @(negedge clk);
    jump_en = 1'b0;
    checks++;
    if (FETCH !== 1'b1 || iAddr !== 8'h20 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL jump_ready_req got fetch=%b iaddr=%h valid=%b want 1 20 0", FETCH, iAddr, ir_valid);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[8'h20]) begin
      errors++; $display("FAIL jump_ready_data got valid=%b ir=%h want 1 %h", ir_valid, ir, mem[8'h20]);
    end
  endtask

  task automatic test_wrap;
    start_run(1'b1, 1'b1);
    jump_en = 1'b1; jump_addr = 8'hFF;
    @(negedge clk);
    jump_en = 1'b0;
    checks++;
    if (FETCH !== 1'b1 || iAddr !== 8'hFF) begin errors++; $display("FAIL wrap_req got fetch=%b iaddr=%h want 1 ff", FETCH, iAddr); end
    @(negedge clk); @(negedge clk);
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[8'hFF]) begin errors++; $display("FAIL wrap_data_ff got valid=%b ir=%h want 1 %h", ir_valid, ir, mem[8'hFF]); end
`ifdef IFU_PC_OVF_EN
    checks++; if (pc_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", pc_ovf); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (FETCH !== 1'b0 || pc_ovf !== 1'b1) begin errors++; $display("FAIL ovf_stop step %0d got fetch=%b ovf=%b want 0 1", k, FETCH, pc_ovf); end
    end
    jump_en = 1'b1; jump_addr = 8'h10;
    @(negedge clk);
    jump_en = 1'b0;
    checks++;
    if (FETCH !== 1'b1 || iAddr !== 8'h10 || pc_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got fetch=%b iaddr=%h ovf=%b want 1 10 0", FETCH, iAddr, pc_ovf);
    end
`else
    @(negedge clk);
    checks++;
    if (FETCH !== 1'b1 || iAddr !== 8'h00) begin errors++; $display("FAIL wrap_req0 got fetch=%b iaddr=%h want 1 00", FETCH, iAddr); end
    @(negedge clk); @(negedge clk);
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[8'h00] || pc_ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_data_00 got valid=%b ir=%h ovf=%b want 1 %h 0", ir_valid, ir, pc_ovf, mem[8'h00]);
    end
`endif
  endtask

  task automatic test_async_reset;
    start_run(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got valid=%b want 1", ir_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ir_valid !== 1'b0 || FETCH !== 1'b0 || ir !== 8'h00 || iAddr !== 8'h00) begin
      errors++; $display("FAIL areset got valid=%b fetch=%b ir=%h iaddr=%h want 0 0 00 00", ir_valid, FETCH, ir, iAddr);
    end
  endtask

  // Transaction model: PC sequence, which byte is held, and when a fetch may start.
  task automatic test_random;
    logic [7:0] model_pc;
    logic [7:0] last_addr;
    bit held_ok, model_ovf, prev_en, prev_jump;
    start_run(1'b1, 1'b1);
    model_pc = 8'h00; last_addr = 8'h00;
    held_ok = 0; model_ovf = 0; prev_en = 1; prev_jump = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (FETCH && !prev_en) begin errors++; $display("FAIL rand_fetch_without_en cycle %0d", c); end
      checks++;
      if (prev_jump && prev_en && !FETCH) begin errors++; $display("FAIL rand_jump_no_fetch cycle %0d got fetch=0 want 1", c); end
      checks++;
      if (FETCH && ir_valid) begin errors++; $display("FAIL rand_fetch_and_valid cycle %0d", c); end
      checks++;
      if (pc_ovf !== model_ovf) begin errors++; $display("FAIL rand_ovf cycle %0d got %b want %b", c, pc_ovf, model_ovf); end
      if (FETCH) begin
        checks++;
        if (iAddr !== model_pc || model_ovf) begin
          errors++; $display("FAIL rand_iaddr cycle %0d got %h want %h ovf=%b", c, iAddr, model_pc, model_ovf);
        end
        last_addr = model_pc;
        held_ok = 1;
`ifdef IFU_PC_OVF_EN
        if (model_pc == 8'hFF) model_ovf = 1;
        else model_pc = model_pc + 8'd1;
`else
        model_pc = model_pc + 8'd1;
`endif
      end
      if (ir_valid) begin
        checks++;
        if (!held_ok || ir !== mem[last_addr]) begin
          errors++; $display("FAIL rand_ir cycle %0d got %h want %h live=%b", c, ir, mem[last_addr], held_ok);
        end
      end
      en = ($urandom % 5) != 0;
      ir_ready = ($urandom % 5) < 3;
      jump_en = ($urandom % 32) == 0;
      jump_addr = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
      if (ir_valid && ir_ready) held_ok = 0;
      if (jump_en) begin model_pc = jump_addr; held_ok = 0; model_ovf = 0; end
      prev_en = en;
      prev_jump = jump_en;
    end
    jump_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
    test_reset;
    test_sequential;
    test_stall;
    test_jump_cap;
    test_jump_vs_ready;
    test_wrap;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator on the instruction-memory read port. It holds the program counter, drives `iAddr`/`FETCH` into the registered instruction memory, and captures the returned byte one cycle later. It presents the captured byte to the decoder with a valid/ready handshake. It supports jumps and stops fetching on demand.

## Interface
- `ADDR_W`, 8: program-counter / `iAddr` width.
- `RESET_PC`, 8'h00: PC value loaded at reset.

- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable. When low, no new fetch is issued.
- `iAddr`  out  ADDR_W  instruction address to memory. Equals the PC register.
- `FETCH`  out  1  memory read strobe. High only in S_REQ.
- `instr`  in  8  memory data. Valid in the cycle after a FETCH cycle.
- `ir`  out  8  instruction register presented to the decoder.
- `ir_valid`  out  1  `ir` holds an unconsumed instruction.
- `ir_ready`  in  1  decoder accepts `ir` on the edge where `ir_valid && ir_ready`.
- `jump_en`  in  1  load PC from `jump_addr`.
- `jump_addr`  in  ADDR_W  jump target.
- `pc_ovf`  out  1  sticky PC overflow flag. Constant 0 unless the configuration macro is enabled.

## Operation
- States:
  - S_IDLE: `FETCH`=0.
    - Goes to S_REQ when `en`=1.
    - Stays in S_IDLE while `pc_ovf`=1.
  - S_REQ: `FETCH`=1, `iAddr`=pc.
    - pc <= pc+1 (mod 2^ADDR_W).
    - Next state is S_CAP.
  - S_CAP: `FETCH`=0.
    - ir <= `instr`.
    - Next state is S_HOLD.
  - S_HOLD: `ir_valid`=1.
    - On `ir_ready`=1, next state is S_REQ if `en`=1, else S_IDLE.
    - Otherwise stays in S_HOLD, and `ir` stays stable.
- `ir_valid` is high exactly in S_HOLD. `FETCH` is high exactly in S_REQ. Both are decoded from the registered state, so neither is driven by a combinational path from an input.
- Jump has the highest priority. It is accepted in any state:
  - pc <= `jump_addr`.
  - Any in-flight or held instruction is discarded, so `ir_valid` is low the next cycle.
  - Next state is S_REQ if `en`=1, else S_IDLE.
  - `pc_ovf` clears.
- Jump and `ir_ready` in the same S_HOLD cycle: the jump wins. The held instruction counts as consumed and is not re-presented.
- A jump in S_REQ still lets the memory read complete. The returned byte is ignored.
- If `en` drops in S_REQ, S_CAP or S_HOLD, the current instruction still completes. No new S_REQ follows.
- Reset values:
  - state=S_IDLE, pc=RESET_PC, ir=8'h00.
  - `FETCH`=0, `ir_valid`=0, `pc_ovf`=0.
- Reset asserted mid-operation returns to these values immediately. A pending instruction is lost.

## Timing
- Reset release edge is E0. With `en`=1:
  - S_IDLE during cycle 0.
  - S_REQ during cycle 1: `FETCH`=1, `iAddr`=RESET_PC.
  - Memory updates `instr` at E2.
  - `ir` loads at E3, and `ir_valid`=1 from cycle 3.
- Fetch-to-valid latency is 2 cycles after the S_REQ cycle.
- With `ir_ready` held high, throughput is one instruction per 3 cycles: S_REQ, S_CAP, S_HOLD.
- After a jump at edge Ej with `en`=1, `FETCH`=1 with `iAddr`=`jump_addr` in the cycle after Ej.

## Configuration
- `IFU_PC_OVF_EN` undefined:
  - The PC wraps from 2^ADDR_W-1 to 0 and fetching continues.
  - `pc_ovf` is tied to 0.
- `IFU_PC_OVF_EN` defined:
  - The S_REQ at pc=2^ADDR_W-1 sets `pc_ovf`=1, and pc holds at 2^ADDR_W-1.
  - The instruction at that address is still delivered through S_HOLD.
  - After its handshake the FSM goes to S_IDLE and stays there, regardless of `en`, until reset or a jump clears `pc_ovf`.

## Test plan
- Memory model preloaded 0x00..0x03 = A1,B2,C3,D4; reset release with `en`=1 and `ir_ready`=1:
  - `FETCH` high in cycles 1, 4, 7, 10 with `iAddr` 0, 1, 2, 3.
  - `ir` A1/B2/C3/D4 valid in cycles 3, 6, 9, 12.
- `ir_ready`=0 for 5 cycles at the first S_HOLD:
  - `ir`=A1 and `ir_valid`=1 stay stable, with no `FETCH`.
  - The next `FETCH` (`iAddr`=1) comes one cycle after `ir_ready` rises.
- `jump_en`=1 with `jump_addr`=0x40 during S_CAP of address 1:
  - `ir_valid` stays low.
  - The next cycle has `FETCH`=1, `iAddr`=0x40, and the byte at 0x40 is presented 2 cycles later.
- Jump and `ir_ready` in the same S_HOLD cycle: the held byte is dropped and the next `FETCH` address equals `jump_addr`.
- Jump to 0xFF, default build: the bytes at 0xFF then 0x00 are delivered in order.
- Jump to 0xFF with `IFU_PC_OVF_EN`:
  - The byte at 0xFF is delivered and `pc_ovf`=1.
  - No further `FETCH` for 20 cycles.
  - A jump to 0x10 clears `pc_ovf` and resumes fetching at 0x10.
- `rst_n` pulsed low during S_HOLD: `ir_valid`, `FETCH` and `ir` go to 0 asynchronously, and `iAddr` goes to RESET_PC.
